// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: datapath width, architectural register count
// and the index of the hardwired zero register.
package cpu_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register write select across all write ports. Storage and read bypass
// both use this one result, so they always agree on which port wins.
module regfile_wr_arb #(
  parameter  int unsigned XLEN  = cpu_pkg::XLEN,
  parameter  int unsigned NREGS = cpu_pkg::NREGS,
  parameter  int unsigned NWP   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic [NWP-1:0]        i_wr_en,
  input  logic [NWP*AW-1:0]     i_wr_addr,
  input  logic [NWP*XLEN-1:0]   i_wr_data,
  output logic [NREGS-1:1]      o_hit,
  output logic [NREGS*XLEN-1:XLEN] o_data
);
  import cpu_pkg::*;

  // Ports are scanned in ascending order, so the highest matching index wins.
  always_comb begin
    o_hit  = '0;
    o_data = '0;
    for (int unsigned a = REG_ZERO + 1; a < NREGS; a++) begin
      for (int unsigned w = 0; w < NWP; w++) begin
        if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == AW'(a))) begin
          o_hit[a]               = 1'b1;
          o_data[a*XLEN +: XLEN] = i_wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered reads, write-to-read
// bypass and a per-register busy scoreboard; x0 reads as zero and never busy.
module regfile_mp #(
  parameter  int unsigned XLEN  = cpu_pkg::XLEN,
  parameter  int unsigned NREGS = cpu_pkg::NREGS,
  parameter  int unsigned NRP   = 2,
  parameter  int unsigned NWP   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP-1:0]        rd_en,
  input  logic [NRP*AW-1:0]     rd_addr,
  output logic [NRP*XLEN-1:0]   rd_data,
  output logic [NRP-1:0]        rd_valid,
  output logic [NRP-1:0]        rd_busy,
  input  logic [NWP-1:0]        wr_en,
  input  logic [NWP*AW-1:0]     wr_addr,
  input  logic [NWP*XLEN-1:0]   wr_data,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr
);
  import cpu_pkg::*;

  logic [XLEN-1:0]         r_regs [REG_ZERO+1:NREGS-1];
  logic [NREGS-1:1]        r_busy;
  logic [NREGS-1:1]        w_hit;
  logic [NREGS*XLEN-1:XLEN] w_wdata;
  logic [NRP*XLEN-1:0]     w_rd_val;
  logic [NRP-1:0]          w_rd_busy;
  logic [NRP*XLEN-1:0]     r_rd_data;
  logic [NRP-1:0]          r_rd_valid;
  logic [NRP-1:0]          r_rd_busy;

  regfile_wr_arb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NWP   (NWP)
  ) u_wr_arb (
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_hit     (w_hit),
    .o_data    (w_wdata)
  );

  // Address 0 matches no entry, so it falls through to zero data and not busy.
  always_comb begin
    w_rd_val  = '0;
    w_rd_busy = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      for (int unsigned a = REG_ZERO + 1; a < NREGS; a++) begin
        if (rd_addr[p*AW +: AW] == AW'(a)) begin
          if (w_hit[a]) begin
            w_rd_val[p*XLEN +: XLEN] = w_wdata[a*XLEN +: XLEN];
            w_rd_busy[p]             = 1'b0;
          end else begin
            w_rd_val[p*XLEN +: XLEN] = r_regs[a];
            w_rd_busy[p]             = r_busy[a];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned a = REG_ZERO + 1; a < NREGS; a++) begin
        r_regs[a] <= '0;
      end
      r_busy     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_rd_busy  <= '0;
    end else begin
      for (int unsigned a = REG_ZERO + 1; a < NREGS; a++) begin
        if (w_hit[a]) begin
          r_regs[a] <= w_wdata[a*XLEN +: XLEN];
        end
        // A newly issued producer outranks a completing write to the same register.
        if (sb_set && (sb_addr == AW'(a))) begin
          r_busy[a] <= 1'b1;
        end else if (w_hit[a]) begin
          r_busy[a] <= 1'b0;
        end
      end
      for (int unsigned p = 0; p < NRP; p++) begin
        r_rd_valid[p] <= rd_en[p];
        if (rd_en[p]) begin
          r_rd_data[p*XLEN +: XLEN] <= w_rd_val[p*XLEN +: XLEN];
          r_rd_busy[p]              <= w_rd_busy[p];
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_busy  = r_rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes expected read results into
// per-port queues; a negedge monitor pops and compares, and checks hold/idle.
module tb_regfile_mp;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRP   = 2;
  localparam int unsigned NWP   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP-1:0]      rd_en;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_valid;
  logic [NRP-1:0]      rd_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRP   (NRP),
    .NWP   (NWP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rst_q = 1'b0;
  logic [31:0] last_d [2];
  logic        last_b [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic mon_port(input int p);
    exp_t        e;
    logic        has;
    logic        v;
    logic [31:0] d;
    logic        b;
    v   = rd_valid[p];
    d   = rd_data[p*32 +: 32];
    b   = rd_busy[p];
    has = 1'b0;
    if (!rst_q) begin
      last_d[p] = '0;
      last_b[p] = 1'b0;
    end
    if (p == 0 && q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front(); has = 1'b1;
    end else if (p == 1 && q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front(); has = 1'b1;
    end
    if (has) begin
      chk($sformatf("rd%0d_valid", p), 32'(v), 32'd1);
      chk($sformatf("rd%0d_data", p), d, e.d);
      chk($sformatf("rd%0d_busy", p), 32'(b), 32'(e.b));
      last_d[p] = e.d;
      last_b[p] = e.b;
    end else begin
      chk($sformatf("rd%0d_idle_valid", p), 32'(v), 32'd0);
      chk($sformatf("rd%0d_hold_data", p), d, last_d[p]);
      chk($sformatf("rd%0d_hold_busy", p), 32'(b), 32'(last_b[p]));
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_port(0);
      mon_port(1);
    end
  end

  task automatic clr();
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic rd(input int p, input int a, input logic [31:0] d, input logic b);
    exp_t e;
    rd_en[p]          = 1'b1;
    rd_addr[p*5 +: 5] = 5'(a);
    e.due = cyc + 1;
    e.d   = d;
    e.b   = b;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    wr_en[w]            = 1'b1;
    wr_addr[w*5 +: 5]   = 5'(a);
    wr_data[w*32 +: 32] = d;
  endtask

  task automatic sb(input int a);
    sb_set  = 1'b1;
    sb_addr = 5'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    last_d[0] = '0; last_d[1] = '0;
    last_b[0] = 1'b0; last_b[1] = 1'b0;
    clr();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      rd(0, i, 32'h0, 1'b0);
      rd(1, 31 - i, 32'h0, 1'b0);
      tick();
    end
    tick();

    wr(0, 5, 32'hDEADBEEF); tick();
    rd(0, 5, 32'hDEADBEEF, 1'b0); rd(1, 5, 32'hDEADBEEF, 1'b0); tick();
    tick();

    wr(1, 0, 32'hFFFFFFFF); tick();
    rd(0, 0, 32'h0, 1'b0); tick();
    wr(0, 0, 32'hFFFFFFFF); rd(1, 0, 32'h0, 1'b0); tick();

    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7, 32'h22, 1'b0); tick();
    rd(1, 7, 32'h22, 1'b0); tick();

    wr(0, 8, 32'h44); wr(1, 10, 32'h55); tick();
    rd(0, 8, 32'h44, 1'b0); rd(1, 10, 32'h55, 1'b0); tick();

    sb(9); tick();
    rd(0, 9, 32'h0, 1'b1); rd(1, 5, 32'hDEADBEEF, 1'b0); tick();
    wr(0, 9, 32'h33); rd(1, 9, 32'h33, 1'b0); tick();
    rd(0, 9, 32'h33, 1'b0); tick();
    sb(9); wr(1, 9, 32'h66); rd(0, 9, 32'h66, 1'b0); tick();
    rd(0, 9, 32'h66, 1'b1); tick();
    sb(0); tick();
    rd(1, 0, 32'h0, 1'b0); tick();
    tick();

    rst = 1'b0;
    rd_en   = 2'b11;
    rd_addr = {5'd9, 5'd5};
    wr(0, 5, 32'h77); wr(1, 12, 32'h88); sb(3);
    tick();
    rst = 1'b1;
    rd(0, 5, 32'h0, 1'b0); rd(1, 9, 32'h0, 1'b0); tick();
    rd(0, 12, 32'h0, 1'b0); rd(1, 3, 32'h0, 1'b0); tick();
    rd(0, 7, 32'h0, 1'b0); rd(1, 8, 32'h0, 1'b0); tick();
    tick(); tick();

    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
